// File: rtl/hybridcore_pkg.sv
// Shared HybridCore definitions: opcode encodings, opcode class predicates,
// special register indices and the write-back FSM state type.
package hybridcore_pkg;

   localparam int OP_W = 5;

   // Opcode encodings. ALU operations occupy 00000..01110.
   localparam logic [OP_W-1:0] OP_ALU_FIRST = 5'b00000;
   localparam logic [OP_W-1:0] OP_ALU_LAST  = 5'b01110;
   localparam logic [OP_W-1:0] OP_CMP       = 5'b01111;
   localparam logic [OP_W-1:0] OP_MOV       = 5'b10000;
   localparam logic [OP_W-1:0] OP_NOP       = 5'b10001;
   localparam logic [OP_W-1:0] OP_LD        = 5'b10010;
   localparam logic [OP_W-1:0] OP_STR       = 5'b10011;
   localparam logic [OP_W-1:0] OP_MSR       = 5'b10100;
   localparam logic [OP_W-1:0] OP_MRS       = 5'b10101;
   localparam logic [OP_W-1:0] OP_PUSH      = 5'b10110;
   localparam logic [OP_W-1:0] OP_POP       = 5'b10111;

   // Architectural register indices with a fixed role.
   localparam int REG_SP   = 28;
   localparam int REG_PC   = 29;
   localparam int REG_CPSR = 30;

   // Write-back FSM: RUN accepts freely, POP_SP issues the deferred SP write.
   typedef enum logic [0:0] {
      WB_RUN    = 1'b0,
      WB_POP_SP = 1'b1
   } wb_state_e;

   // ALU ops write a register and the flags.
   function automatic logic is_alu_wr(input logic [OP_W-1:0] op);
      return (op <= OP_ALU_LAST);
   endfunction

   // ALU ops and CMP update CPSR flags.
   function automatic logic is_flag_wr(input logic [OP_W-1:0] op);
      return (op <= OP_CMP);
   endfunction

   // Ops that write in_reg_dst with in_result in the cycle after accept.
   // POP is included: its first commit is the destination register.
   function automatic logic is_reg_wr(input logic [OP_W-1:0] op);
      return is_alu_wr(op) || (op == OP_MOV) || (op == OP_LD) ||
             (op == OP_MSR) || (op == OP_MRS) || (op == OP_POP);
   endfunction

   // Ops that enqueue an entry into the store buffer.
   function automatic logic is_store(input logic [OP_W-1:0] op);
      return (op == OP_STR) || (op == OP_PUSH);
   endfunction

   function automatic logic is_push(input logic [OP_W-1:0] op);
      return (op == OP_PUSH);
   endfunction

   function automatic logic is_pop(input logic [OP_W-1:0] op);
      return (op == OP_POP);
   endfunction

endpackage

// File: rtl/wb_store_fifo.sv
// Store buffer for the write-back stage: a FIFO of {addr,data} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head entry is presented combinationally and only changes on a pop,
// so it stays stable while the consumer stalls.
module wb_store_fifo #(
   parameter int DATA_W   = 16,
   parameter int SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_addr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [DATA_W-1:0] head_addr_o,
   output logic [DATA_W-1:0] head_data_o
);

   localparam int AW = $clog2(SB_DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] addr_mem_q [SB_DEPTH];
   logic [DATA_W-1:0] data_mem_q [SB_DEPTH];
   logic              push_ok;
   logic              pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A push into a full buffer is dropped; the stage never issues one
   // because in_ready already blocks stores while full.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Stale storage is masked so the drain port reads zero while empty.
   assign head_addr_o = empty_o ? '0 : addr_mem_q[rd_ptr_q[AW-1:0]];
   assign head_data_o = empty_o ? '0 : data_mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values for enqueue and dequeue.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers; reset discards every buffered entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem_q[wr_ptr_q[AW-1:0]] <= push_addr_i;
         data_mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// HybridCore write-back stage. Commits register results and CPSR flags one
// cycle after accept, queues STR/PUSH into the store buffer, and splits POP
// into a destination-register write followed by an SP write.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload steady while valid && !ready, and
// ready may depend combinationally on the presented payload (in_ready looks
// at in_op to stall only stores when the buffer is full).
module wb_stage
   import hybridcore_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_IDX_W = 5,
   parameter int SB_DEPTH  = 4,
   parameter int SP_IDX    = REG_SP
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_W-1:0]      in_op,
   input  logic [DATA_W-1:0]    in_result,
   input  logic [DATA_W-1:0]    in_operand_b,
   input  logic [REG_IDX_W-1:0] in_reg_dst,
   input  logic [3:0]           in_nzcv,
   input  logic [DATA_W-1:0]    sp_rdata,
   output logic                 reg_w_en,
   output logic [REG_IDX_W-1:0] reg_w_idx,
   output logic [DATA_W-1:0]    reg_w_data,
   output logic                 cpsr_w_en,
   output logic [3:0]           cpsr_nzcv,
   output logic                 mem_w_valid,
   input  logic                 mem_w_ready,
   output logic [DATA_W-1:0]    mem_w_addr,
   output logic [DATA_W-1:0]    mem_w_data,
   output logic                 sb_empty,
   output logic                 byp_valid,
   output logic [REG_IDX_W-1:0] byp_idx,
   output logic [DATA_W-1:0]    byp_data,
   output wb_state_e            dbg_state
);

   localparam logic [REG_IDX_W-1:0] SP_REG = REG_IDX_W'(SP_IDX);

   wb_state_e              state_q, state_d;
   logic [DATA_W-1:0]      pop_sp_q, pop_sp_d;

   logic                   reg_w_en_q, reg_w_en_d;
   logic [REG_IDX_W-1:0]   reg_w_idx_q, reg_w_idx_d;
   logic [DATA_W-1:0]      reg_w_data_q, reg_w_data_d;
   logic                   cpsr_w_en_q, cpsr_w_en_d;
   logic [3:0]             cpsr_nzcv_q, cpsr_nzcv_d;

   logic                   accept;
   logic                   pop_sp_wr;
   logic                   sb_full;
   logic                   sb_empty_w;
   logic                   sb_push;
   logic [DATA_W-1:0]      sb_push_addr;
   logic [DATA_W-1:0]      sb_push_data;
   logic [DATA_W-1:0]      sp_dec;

   assign accept = in_valid && in_ready;

   // SP arithmetic wraps modulo 2^DATA_W.
   assign sp_dec = sp_rdata - DATA_W'(1);

   // ---------------------------------------------------------------- FSM

   // State register; reset drops any pending POP SP write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= WB_RUN;
         pop_sp_q <= '0;
      end else begin
         state_q  <= state_d;
         pop_sp_q <= pop_sp_d;
      end
   end

   // Next state: a POP accept latches SP and defers its increment a cycle.
   always_comb begin
      state_d  = state_q;
      pop_sp_d = pop_sp_q;
      case (state_q)
         WB_RUN: begin
            if (accept && is_pop(in_op)) begin
               state_d  = WB_POP_SP;
               pop_sp_d = sp_rdata;
            end
         end
         WB_POP_SP: state_d = WB_RUN;
         default:   state_d = WB_RUN;
      endcase
   end

   // FSM outputs: acceptance gate and the deferred SP write strobe.
   always_comb begin
      in_ready  = 1'b0;
      pop_sp_wr = 1'b0;
      case (state_q)
         WB_RUN:    in_ready  = !reset && !(sb_full && is_store(in_op));
         WB_POP_SP: pop_sp_wr = 1'b1;
         default:   in_ready  = 1'b0;
      endcase
   end

   assign dbg_state = state_q;

   // -------------------------------------------------------- write mux

   // Select the register and flag commit for the next cycle. The POP SP
   // write never collides with an accept because in_ready is low in POP_SP.
   always_comb begin
      reg_w_en_d   = 1'b0;
      reg_w_idx_d  = reg_w_idx_q;
      reg_w_data_d = reg_w_data_q;
      cpsr_w_en_d  = 1'b0;
      cpsr_nzcv_d  = cpsr_nzcv_q;
      if (pop_sp_wr) begin
         reg_w_en_d   = 1'b1;
         reg_w_idx_d  = SP_REG;
         reg_w_data_d = pop_sp_q + DATA_W'(1);
      end else if (accept) begin
         if (is_push(in_op)) begin
            reg_w_en_d   = 1'b1;
            reg_w_idx_d  = SP_REG;
            reg_w_data_d = sp_dec;
         end else if (is_reg_wr(in_op)) begin
            reg_w_en_d   = 1'b1;
            reg_w_idx_d  = in_reg_dst;
            reg_w_data_d = in_result;
         end
         if (is_flag_wr(in_op)) begin
            cpsr_w_en_d = 1'b1;
            cpsr_nzcv_d = in_nzcv;
         end
      end
   end

   // Commit registers: enables pulse for one cycle, data holds afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_w_en_q   <= 1'b0;
         reg_w_idx_q  <= '0;
         reg_w_data_q <= '0;
         cpsr_w_en_q  <= 1'b0;
         cpsr_nzcv_q  <= '0;
      end else begin
         reg_w_en_q   <= reg_w_en_d;
         reg_w_idx_q  <= reg_w_idx_d;
         reg_w_data_q <= reg_w_data_d;
         cpsr_w_en_q  <= cpsr_w_en_d;
         cpsr_nzcv_q  <= cpsr_nzcv_d;
      end
   end

   assign reg_w_en   = reg_w_en_q;
   assign reg_w_idx  = reg_w_idx_q;
   assign reg_w_data = reg_w_data_q;
   assign cpsr_w_en  = cpsr_w_en_q;
   assign cpsr_nzcv  = cpsr_nzcv_q;

   // The bypass is the register write port seen from execute.
   assign byp_valid = reg_w_en_q;
   assign byp_idx   = reg_w_idx_q;
   assign byp_data  = reg_w_data_q;

   // ------------------------------------------------------ store buffer

   // PUSH stores to the pre-decremented SP; STR uses the computed address.
   assign sb_push      = accept && is_store(in_op);
   assign sb_push_addr = is_push(in_op) ? sp_dec    : in_result;
   assign sb_push_data = is_push(in_op) ? in_result : in_operand_b;

   wb_store_fifo #(
      .DATA_W   (DATA_W),
      .SB_DEPTH (SB_DEPTH)
   ) u_store_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (sb_push),
      .push_addr_i (sb_push_addr),
      .push_data_i (sb_push_data),
      .pop_i       (mem_w_valid && mem_w_ready),
      .full_o      (sb_full),
      .empty_o     (sb_empty_w),
      .head_addr_o (mem_w_addr),
      .head_data_o (mem_w_data)
   );

   assign mem_w_valid = !sb_empty_w;
   assign sb_empty    = sb_empty_w;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: commits, flags, PUSH/POP SP handling,
// store-buffer fill/drain ordering, stall stability and mid-operation reset.
module tb_wb_stage;
   import hybridcore_pkg::*;

   localparam int DATA_W    = 16;
   localparam int REG_IDX_W = 5;
   localparam int SB_DEPTH  = 4;

   logic                 clk;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [4:0]           in_op;
   logic [DATA_W-1:0]    in_result;
   logic [DATA_W-1:0]    in_operand_b;
   logic [REG_IDX_W-1:0] in_reg_dst;
   logic [3:0]           in_nzcv;
   logic [DATA_W-1:0]    sp_rdata;
   logic                 reg_w_en;
   logic [REG_IDX_W-1:0] reg_w_idx;
   logic [DATA_W-1:0]    reg_w_data;
   logic                 cpsr_w_en;
   logic [3:0]           cpsr_nzcv;
   logic                 mem_w_valid;
   logic                 mem_w_ready;
   logic [DATA_W-1:0]    mem_w_addr;
   logic [DATA_W-1:0]    mem_w_data;
   logic                 sb_empty;
   logic                 byp_valid;
   logic [REG_IDX_W-1:0] byp_idx;
   logic [DATA_W-1:0]    byp_data;
   wb_state_e            dbg_state;

   int total = 0;
   int bad   = 0;

   // Expected drain order, each entry {addr, data}.
   logic [31:0] exp_q[$];

   wb_stage #(
      .DATA_W    (DATA_W),
      .REG_IDX_W (REG_IDX_W),
      .SB_DEPTH  (SB_DEPTH),
      .SP_IDX    (28)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_result    (in_result),
      .in_operand_b (in_operand_b),
      .in_reg_dst   (in_reg_dst),
      .in_nzcv      (in_nzcv),
      .sp_rdata     (sp_rdata),
      .reg_w_en     (reg_w_en),
      .reg_w_idx    (reg_w_idx),
      .reg_w_data   (reg_w_data),
      .cpsr_w_en    (cpsr_w_en),
      .cpsr_nzcv    (cpsr_nzcv),
      .mem_w_valid  (mem_w_valid),
      .mem_w_ready  (mem_w_ready),
      .mem_w_addr   (mem_w_addr),
      .mem_w_data   (mem_w_data),
      .sb_empty     (sb_empty),
      .byp_valid    (byp_valid),
      .byp_idx      (byp_idx),
      .byp_data     (byp_data),
      .dbg_state    (dbg_state)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [15:0] res, input logic [15:0] opb,
                        input logic [4:0] dst, input logic [3:0] nzcv, input logic [15:0] sp);
      in_valid     = 1'b1;
      in_op        = op;
      in_result    = res;
      in_operand_b = opb;
      in_reg_dst   = dst;
      in_nzcv      = nzcv;
      sp_rdata     = sp;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic en, input logic [4:0] idx, input logic [15:0] data);
      chk({tag, "_en"}, {31'd0, reg_w_en}, {31'd0, en});
      chk({tag, "_byp_v"}, {31'd0, byp_valid}, {31'd0, en});
      if (en) begin
         chk({tag, "_idx"}, {27'd0, reg_w_idx}, {27'd0, idx});
         chk({tag, "_data"}, {16'd0, reg_w_data}, {16'd0, data});
         chk({tag, "_byp_idx"}, {27'd0, byp_idx}, {27'd0, idx});
         chk({tag, "_byp_data"}, {16'd0, byp_data}, {16'd0, data});
      end
   endtask

   logic [31:0] e;
   int          k;
   logic        acc_now;
   logic        fifth_acc;

   initial begin
      // ---------------------------------------------------- reset
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_op        = OP_NOP;
      in_result    = '0;
      in_operand_b = '0;
      in_reg_dst   = '0;
      in_nzcv      = '0;
      sp_rdata     = '0;
      mem_w_ready  = 1'b0;
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_reg_en", {31'd0, reg_w_en}, 32'd0);
      chk("rst_reg_idx", {27'd0, reg_w_idx}, 32'd0);
      chk("rst_reg_data", {16'd0, reg_w_data}, 32'd0);
      chk("rst_cpsr_en", {31'd0, cpsr_w_en}, 32'd0);
      chk("rst_mem_valid", {31'd0, mem_w_valid}, 32'd0);
      chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
      chk("rst_state", {31'd0, dbg_state}, {31'd0, WB_RUN});
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

      // ---------------------------------------------------- ADD
      drive(OP_ALU_FIRST, 16'h1234, 16'h0000, 5'd5, 4'b0100, 16'h0000);
      step();
      idle();
      chk_reg("add", 1'b1, 5'd5, 16'h1234);
      chk("add_cpsr_en", {31'd0, cpsr_w_en}, 32'd1);
      chk("add_nzcv", {28'd0, cpsr_nzcv}, 32'h4);
      step();
      chk("add_pulse_en", {31'd0, reg_w_en}, 32'd0);
      chk("add_pulse_cpsr", {31'd0, cpsr_w_en}, 32'd0);

      // ---------------------------------------------------- CMP: flags only
      drive(OP_CMP, 16'h5555, 16'h0000, 5'd7, 4'b1010, 16'h0000);
      step();
      idle();
      chk_reg("cmp", 1'b0, 5'd0, 16'h0);
      chk("cmp_cpsr_en", {31'd0, cpsr_w_en}, 32'd1);
      chk("cmp_nzcv", {28'd0, cpsr_nzcv}, 32'hA);

      // ---------------------------------------------------- MOV then NOP
      drive(OP_MOV, 16'h0F0F, 16'h0000, 5'd9, 4'b1111, 16'h0000);
      step();
      drive(OP_NOP, 16'hDEAD, 16'hBEEF, 5'd2, 4'b1111, 16'h0000);
      chk_reg("mov", 1'b1, 5'd9, 16'h0F0F);
      chk("mov_cpsr_en", {31'd0, cpsr_w_en}, 32'd0);
      step();
      idle();
      chk_reg("nop", 1'b0, 5'd0, 16'h0);
      chk("nop_cpsr_en", {31'd0, cpsr_w_en}, 32'd0);
      chk("nop_sb_empty", {31'd0, sb_empty}, 32'd1);

      // ---------------------------------------------------- PUSH at SP=0 wraps
      drive(OP_PUSH, 16'hBEEF, 16'h0000, 5'd0, 4'b0000, 16'h0000);
      step();
      idle();
      chk_reg("push", 1'b1, 5'd28, 16'hFFFF);
      chk("push_cpsr_en", {31'd0, cpsr_w_en}, 32'd0);
      chk("push_mem_valid", {31'd0, mem_w_valid}, 32'd1);
      chk("push_mem_addr", {16'd0, mem_w_addr}, 32'hFFFF);
      chk("push_mem_data", {16'd0, mem_w_data}, 32'hBEEF);
      chk("push_sb_empty", {31'd0, sb_empty}, 32'd0);
      mem_w_ready = 1'b1;
      step();
      mem_w_ready = 1'b0;
      chk("push_drained", {31'd0, sb_empty}, 32'd1);
      chk("push_mem_valid_off", {31'd0, mem_w_valid}, 32'd0);

      // ---------------------------------------------------- POP: dst then SP
      drive(OP_POP, 16'h00AA, 16'h0000, 5'd3, 4'b0000, 16'h0100);
      step();
      idle();
      chk_reg("pop_dst", 1'b1, 5'd3, 16'h00AA);
      chk("pop_dst_ready", {31'd0, in_ready}, 32'd0);
      chk("pop_state", {31'd0, dbg_state}, {31'd0, WB_POP_SP});
      sp_rdata = 16'h7777;  // SP write must use the value latched at accept
      step();
      chk_reg("pop_sp", 1'b1, 5'd28, 16'h0101);
      chk("pop_sp_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("pop_done_en", {31'd0, reg_w_en}, 32'd0);

      // ---------------------------------------------------- POP at SP=0xFFFF wraps
      drive(OP_POP, 16'h1111, 16'h0000, 5'd4, 4'b0000, 16'hFFFF);
      step();
      idle();
      chk_reg("popw_dst", 1'b1, 5'd4, 16'h1111);
      step();
      chk_reg("popw_sp", 1'b1, 5'd28, 16'h0000);

      // ---------------------------------------------------- fill buffer with stores
      mem_w_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(OP_STR, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 5'd0, 4'b0000, 16'h0000);
         chk($sformatf("fill_ready_%0d", i), {31'd0, in_ready}, 32'd1);
         exp_q.push_back({16'h0100 + 16'(i), 16'hA000 + 16'(i)});
         step();
      end
      drive(OP_STR, 16'h0104, 16'hA004, 5'd0, 4'b0000, 16'h0000);
      chk("full_str_stall", {31'd0, in_ready}, 32'd0);
      chk("full_no_reg_wr", {31'd0, reg_w_en}, 32'd0);
      // Non-store ops are not blocked by a full buffer.
      in_op = OP_ALU_FIRST;
      #1;
      chk("full_alu_ready", {31'd0, in_ready}, 32'd1);
      in_op = OP_STR;
      #1;
      // Head stays stable while the drain port stalls.
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("stall_addr_%0d", i), {16'd0, mem_w_addr}, 32'h0100);
         chk($sformatf("stall_data_%0d", i), {16'd0, mem_w_data}, 32'hA000);
         chk($sformatf("stall_ready_%0d", i), {31'd0, in_ready}, 32'd0);
         step();
      end

      // Dequeue in the same cycle does not open a slot for a store.
      mem_w_ready = 1'b1;
      #1;
      chk("full_no_passthru", {31'd0, in_ready}, 32'd0);

      // ---------------------------------------------------- drain in order
      k         = 0;
      fifth_acc = 1'b0;
      for (int c = 0; c < 20 && k < 5; c++) begin
         if (mem_w_valid) begin
            if (exp_q.size() == 0) begin
               chk("drain_extra", {31'd0, mem_w_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("drain_addr_%0d", k), {16'd0, mem_w_addr}, {16'd0, e[31:16]});
               chk($sformatf("drain_data_%0d", k), {16'd0, mem_w_data}, {16'd0, e[15:0]});
            end
            k++;
         end
         acc_now = in_valid && in_ready;
         step();
         if (acc_now) begin
            idle();
            fifth_acc = 1'b1;
            exp_q.push_back({16'h0104, 16'hA004});
         end
      end
      chk("drain_count", k, 32'd5);
      chk("fifth_accepted", {31'd0, fifth_acc}, 32'd1);
      chk("drain_empty", {31'd0, sb_empty}, 32'd1);
      chk("drain_q_empty", exp_q.size(), 32'd0);

      // ---------------------------------------------------- enqueue+dequeue at 2 entries
      mem_w_ready = 1'b0;
      drive(OP_STR, 16'h0200, 16'hB000, 5'd0, 4'b0000, 16'h0000);
      step();
      drive(OP_STR, 16'h0201, 16'hB001, 5'd0, 4'b0000, 16'h0000);
      step();
      drive(OP_STR, 16'h0202, 16'hB002, 5'd0, 4'b0000, 16'h0000);
      mem_w_ready = 1'b1;
      #1;
      chk("sim_ready", {31'd0, in_ready}, 32'd1);
      chk("sim_head_before", {16'd0, mem_w_addr}, 32'h0200);
      step();
      idle();
      mem_w_ready = 1'b0;
      #1;
      chk("sim_head_after", {16'd0, mem_w_addr}, 32'h0201);
      chk("sim_data_after", {16'd0, mem_w_data}, 32'hB001);
      mem_w_ready = 1'b1;
      step();
      chk("sim_second_valid", {31'd0, mem_w_valid}, 32'd1);
      chk("sim_second_addr", {16'd0, mem_w_addr}, 32'h0202);
      chk("sim_second_data", {16'd0, mem_w_data}, 32'hB002);
      step();
      chk("sim_count2_empty", {31'd0, sb_empty}, 32'd1);
      mem_w_ready = 1'b0;

      // ---------------------------------------------------- reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(OP_STR, 16'h0300 + 16'(i), 16'hC000 + 16'(i), 5'd0, 4'b0000, 16'h0000);
         step();
      end
      drive(OP_POP, 16'h0055, 16'h0000, 5'd6, 4'b0000, 16'h0400);
      step();
      idle();
      chk("mid_pop_state", {31'd0, dbg_state}, {31'd0, WB_POP_SP});
      chk("mid_sb_busy", {31'd0, sb_empty}, 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_rst_reg_en", {31'd0, reg_w_en}, 32'd0);
      chk("mid_rst_reg_idx", {27'd0, reg_w_idx}, 32'd0);
      chk("mid_rst_reg_data", {16'd0, reg_w_data}, 32'd0);
      chk("mid_rst_byp", {31'd0, byp_valid}, 32'd0);
      chk("mid_rst_cpsr", {31'd0, cpsr_w_en}, 32'd0);
      chk("mid_rst_nzcv", {28'd0, cpsr_nzcv}, 32'd0);
      chk("mid_rst_mem_valid", {31'd0, mem_w_valid}, 32'd0);
      chk("mid_rst_mem_addr", {16'd0, mem_w_addr}, 32'd0);
      chk("mid_rst_mem_data", {16'd0, mem_w_data}, 32'd0);
      chk("mid_rst_sb_empty", {31'd0, sb_empty}, 32'd1);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_state", {31'd0, dbg_state}, {31'd0, WB_RUN});
      step();
      step();
      reset = 1'b0;
      mem_w_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_rst_no_wr_%0d", i), {31'd0, reg_w_en}, 32'd0);
         chk($sformatf("post_rst_no_mem_%0d", i), {31'd0, mem_w_valid}, 32'd0);
      end
      chk("post_rst_ready2", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the HybridCore pipeline, placed between execute and the register file / data-memory write port. It accepts one retired instruction per cycle over a valid/ready handshake and commits register results and CPSR flags. Stores and PUSHes are queued in an internal store buffer that drains to memory over its own handshake. POP commits both its destination register and the SP increment, and every register commit is forwarded to execute as a bypass.

## Interface
Parameters:
- DATA_W, 16, datapath / address width
- REG_IDX_W, 5, register index width (32 architectural registers)
- SB_DEPTH, 4, store-buffer entries (power of two, >= 2)
- SP_IDX, 28, index of SP in the register file

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_op  in  5  opcode
- in_result  in  DATA_W  ALU result / load data / store address
- in_operand_b  in  DATA_W  store data
- in_reg_dst  in  REG_IDX_W  destination register
- in_nzcv  in  4  flags from execute
- sp_rdata  in  DATA_W  current SP from register file
- reg_w_en / reg_w_idx / reg_w_data  out  1 / REG_IDX_W / DATA_W  register-file write port
- cpsr_w_en / cpsr_nzcv  out  1 / 4  flag update
- mem_w_valid / mem_w_ready  out / in  1 / 1  store-buffer drain handshake
- mem_w_addr / mem_w_data  out  DATA_W each  head entry of store buffer
- sb_empty  out  1  store buffer empty (used as a fence by fetch)
- byp_valid / byp_idx / byp_data  out  1 / REG_IDX_W / DATA_W  bypass to execute

## Operation
- Accept happens when in_valid && in_ready.
- Opcode classes:
  - ALU 00000-01110: write reg and flags.
  - CMP 01111: flags only.
  - MOV 10000, LD 10010, MSR 10100, MRS 10101: write reg.
  - STR 10011: enqueue {addr=in_result, data=in_operand_b}.
  - PUSH 10110: enqueue {addr=sp_rdata-1, data=in_result} and write SP=sp_rdata-1.
  - POP 10111: write in_reg_dst=in_result, then SP=sp_rdata+1.
  - 10001 and all others: no side effect.
- SP arithmetic is modulo 2^DATA_W: PUSH at SP=0 gives 0xFFFF; POP at SP=0xFFFF gives 0.
- FSM states:
  - RUN: accept freely.
  - POP_SP: entered on POP accept; issues the SP write in the next cycle with the sp value latched at accept, deasserts in_ready, then returns to RUN.
- in_ready = (state==RUN) && !(sb_full && in_op is STR/PUSH).
- Store buffer is a FIFO. mem_w_valid = !empty, and addr/data hold stable while valid && !ready. An entry pops on mem_w_valid && mem_w_ready.
- Enqueue and dequeue in the same cycle are legal when not full. When full, a store stalls even if a dequeue occurs that cycle (no pass-through).
- Bypass mirrors the register write exactly: byp_valid=reg_w_en, same idx and data.

## Timing
- reg_w_*, cpsr_*, and byp_* are registered and assert for exactly one cycle, the cycle after accept. The POP SP write follows one cycle later.
- A store is visible on mem_w_* the cycle after accept if the buffer was empty (1-cycle latency).
- Reset values: in_ready=0 while reset is high, then 1. All enables and valids are 0, all data/idx outputs are 0, sb_empty=1, state=RUN.
- Reset mid-operation discards all buffered stores and any pending POP SP write.

## Structure
- Package hybridcore_pkg holds the opcode constants and class predicates (is_alu_wr, is_store, ...), plus REG_SP/REG_PC/REG_CPSR indices. The stage shares these with the decode and execute stages.
- Sub-module wb_store_fifo (params DATA_W, SB_DEPTH) holds {addr,data} entries with read/write pointers one bit wider than the index for full/empty. wb_stage contains the FSM, the write mux, and the bypass registers.

## Test plan
- ADD (00000) with result 0x1234, dst 5, nzcv 0b0100 -> next cycle reg_w_en=1 idx=5 data=0x1234, cpsr_w_en=1 nzcv=0100, byp matches; CMP -> cpsr only.
- PUSH with sp_rdata=0x0000 and result 0xBEEF -> SP write 0xFFFF; mem_w_addr=0xFFFF, data=0xBEEF.
- POP with dst 3, result 0x00AA, sp 0x0100 -> cycle+1 writes r3=0x00AA with in_ready=0; cycle+2 writes r28=0x0101; in_ready=1 after that.
- 5 back-to-back STRs with mem_w_ready=0 -> 4 accepted, in_ready drops on the 5th. Raise mem_w_ready -> drains in order, 5th accepted once a slot frees, sb_empty=1 at end.
- Hold mem_w_ready=0 and check mem_w_addr/data stay stable for 10 cycles; simultaneous enqueue+dequeue at 2 entries keeps the count at 2.
- Assert reset with 3 stores queued and a POP_SP pending -> all outputs zero, sb_empty=1, no SP write after release.
